// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler that hands out steps of one shared 4-bit LFSR, one draw per grant.
// A warm-up phase after reset or reseed advances the LFSR before any grant is issued.
module lfsr_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int WARMUP  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       seed_we_i,
  input  logic [3:0]                 seed_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id_o,
  output logic                       valid_o,
  output logic [3:0]                 data_o,
  output logic                       busy_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [CW-1:0] WLAST = CW'((WARMUP > 0) ? WARMUP - 1 : 0);

  typedef enum logic {WARM, SERVE} state_t;
  localparam state_t INIT_ST = (WARMUP == 0) ? SERVE : WARM;

  state_t               state, state_n;
  logic [3:0]           lfsr, lfsr_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        ptr, ptr_n;
  logic [NUM_REQ-1:0]   gnt_n;
  logic [IW-1:0]        id_n;
  logic                 valid_n;
  logic [3:0]           data_n;

  logic [2*NUM_REQ-1:0] req_rot2;
  logic [IW-1:0]        off, win;
  logic [IW:0]          sum;
  logic                 found;

  function automatic logic [3:0] lfsr_step(input logic [3:0] s);
    return {s[2:0], s[1] ^ s[3]};
  endfunction

  // Rotate requests so that ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    req_rot2 = {req_i, req_i} >> ptr;
    found    = |req_i;
    off      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_rot2[i]) off = IW'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
    win = sum[IW-1:0];
  end

  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    cnt_n   = cnt;
    ptr_n   = ptr;
    gnt_n   = '0;
    valid_n = 1'b0;
    id_n    = gnt_id_o;
    data_n  = data_o;
    if (seed_we_i) begin
      // All-zero seed would lock the LFSR, so it is replaced by 1111.
      lfsr_n  = (seed_i == 4'h0) ? 4'hF : seed_i;
      cnt_n   = '0;
      state_n = INIT_ST;
    end else begin
      case (state)
        WARM: begin
          lfsr_n = lfsr_step(lfsr);
          cnt_n  = cnt + CW'(1);
          if (cnt == WLAST) state_n = SERVE;
        end
        SERVE: begin
          if (found) begin
            gnt_n   = NUM_REQ'(1) << win;
            id_n    = win;
            data_n  = lfsr;
            valid_n = 1'b1;
            lfsr_n  = lfsr_step(lfsr);
            ptr_n   = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
          end
        end
        default: state_n = INIT_ST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= INIT_ST;
      lfsr     <= 4'hF;
      cnt      <= '0;
      ptr      <= '0;
      gnt_o    <= '0;
      gnt_id_o <= '0;
      valid_o  <= 1'b0;
      data_o   <= 4'h0;
    end else begin
      state    <= state_n;
      lfsr     <= lfsr_n;
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      gnt_o    <= gnt_n;
      gnt_id_o <= id_n;
      valid_o  <= valid_n;
      data_o   <= data_n;
    end
  end

  assign busy_o = (state == WARM);

endmodule

// File: doc/lfsr_rr_sched.md
# lfsr_rr_sched

Round-robin scheduler that shares one 4-bit LFSR among `NUM_REQ` requesters. Each grant delivers the current LFSR value to exactly one requester and advances the LFSR by one step, so no two consumers ever receive the same draw. After reset and after every reseed, the block runs a programmable warm-up, stepping the LFSR without issuing grants. It sits between the pseudo-random source and its consumers, such as test-pattern generators and randomized arbiters.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `WARMUP`, default 4: LFSR steps taken after reset or seed load before serving. 0 means no warm-up.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `req_i`, input, `NUM_REQ`: level request, one bit per requester.
- `seed_we_i`, input, 1: load `seed_i` into the LFSR this edge.
- `seed_i`, input, 4: seed value.
- `gnt_o`, output, `NUM_REQ`: one-hot grant, registered, one cycle wide.
- `gnt_id_o`, output, `$clog2(NUM_REQ)`: index of the granted requester.
- `valid_o`, output, 1: `gnt_o`, `gnt_id_o` and `data_o` are valid this cycle.
- `data_o`, output, 4: LFSR value delivered with the grant.
- `busy_o`, output, 1: block is in warm-up.

## Operation
- LFSR step is fixed: next = {lfsr[2:0], lfsr[1]^lfsr[3]}.
- From 1111 the cycle is 1111→1110→1100→1001→0011→0111→1111 (period 6).
- State 0000 is a lockup state and must never be entered.

FSM states:
- **WARM**
  - Each edge: LFSR steps and `cnt` increments; no grants; `busy_o`=1.
  - When `cnt` reaches `WARMUP`-1, the FSM goes to SERVE on that edge.
  - If `WARMUP`=0, WARM is skipped: reset and seed load enter SERVE directly.
- **SERVE**
  - On an edge with `req_i` != 0 and `seed_we_i`=0:
    - Winner = first set bit searching upward from `ptr`, wrapping modulo `NUM_REQ`.
    - `gnt_o` = onehot(winner), `gnt_id_o` = winner, `data_o` = LFSR value before the step, `valid_o`=1.
    - LFSR steps; `ptr` <= (winner+1) mod `NUM_REQ`.
  - On an edge with no request: `valid_o`=0, `gnt_o`=0, LFSR holds, `ptr` holds; `data_o` and `gnt_id_o` hold their last values.

Seed load:
- `seed_we_i`=1 in any state: LFSR <= `seed_i`, or 1111 if `seed_i`=0000.
- Then `cnt`<=0 and the FSM goes to WARM (or to SERVE if `WARMUP`=0).
- No grant is issued on a seed edge; `valid_o`<=0 and `ptr` is unchanged.
- Seed beats any request presented on the same edge.

Request handling:
- Requests are not queued. A requester that sees its `gnt_o` and still holds `req_i` competes again on the next edge.
- A sole active requester is granted every cycle.

## Timing
- Reset (`reset`=0 at an edge) sets:
  - LFSR=1111, `ptr`=0, `cnt`=0.
  - `gnt_o`=0, `gnt_id_o`=0, `valid_o`=0, `data_o`=0000.
  - FSM=WARM with `busy_o`=1, or SERVE with `busy_o`=0 if `WARMUP`=0.
- Reset asserted mid-grant: all outputs take their reset values after that edge; any in-flight grant is dropped.
- Warm-up length: `busy_o` stays 1 for exactly `WARMUP` cycles after reset release or seed edge, and reads 0 from the following cycle.
- With `WARMUP`=4 the first served value after reset is 0011.
- Grant latency: `req_i` sampled at edge N produces `valid_o`/`gnt_o` during cycle N→N+1. Throughput is one grant per cycle.
- `req_i` is ignored while `busy_o`=1 (WARM).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Warm-up:** `WARMUP`=4, reset, then `req_i`=0 → `busy_o`=1 for 4 cycles then 0, `valid_o` never 1, and the next grant carries `data_o`=0011.
- **Sole requester:** `req_i`=0001 held in SERVE → `valid_o` continuous, `gnt_id_o`=0 every cycle, `data_o`=0011,0111,1111,1110,1100,1001,0011.
- **Round-robin fairness:** `req_i`=1111 held → `gnt_id_o`=0,1,2,3,0,1 with `data_o` advancing one LFSR step per grant. With `req_i`=1010 → `gnt_id_o` alternates 1,3.
- **Seed and zero guard:**
  - `WARMUP`=0, seed 0001 → grants deliver 0001,0010,0101,1010.
  - Seed 0000 → next grants deliver 1111,1110.
- **Seed/request collision:** `seed_we_i` and `req_i`≠0 on the same edge → no grant that cycle; LFSR=seed; `busy_o`=1 for `WARMUP` cycles; `ptr` unchanged.
- **Reset mid-grant:** `reset`=0 during a `valid_o`=1 stream → next cycle `gnt_o`=0, `valid_o`=0, `data_o`=0000, `busy_o`=1; after release the sequence restarts from the first served value 0011 (`WARMUP`=4).
